// File: rtl/sqrt_mag_seq.sv
// Magnitude approximation sequencer: drives an external abs/min/max unit through
// |a|, |b|, max, min, then forms max(x - x/8 + y/2, x) locally.
module sqrt_mag_seq #(
  parameter int unsigned W      = 8,
  parameter int unsigned AU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_sat,
  output logic [W-1:0] au_a,
  output logic [W-1:0] au_b,
  output logic [1:0]   au_sel,
  input  logic [W-1:0] au_out
);

  localparam int unsigned CW = $clog2(AU_LAT + 2);
  localparam logic [CW-1:0] LAT = CW'(AU_LAT);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ABS_A = 3'd1;
  localparam logic [2:0] ST_ABS_B = 3'd2;
  localparam logic [2:0] ST_MAX   = 3'd3;
  localparam logic [2:0] ST_MIN   = 3'd4;
  localparam logic [2:0] ST_CALC  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [1:0] SEL_ABS = 2'b00;
  localparam logic [1:0] SEL_MIN = 2'b10;
  localparam logic [1:0] SEL_MAX = 2'b11;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

  logic [2:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  b_q;
  logic          sat_q;
  logic [W-1:0]  ra_q;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic          lat_hit;
  logic [W:0]    x_ext;
  logic [W:0]    r_sum;
  logic [W-1:0]  result;

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    return (v == MOST_NEG) ? MOST_POS : v;
  endfunction

  assign in_ready = (state_q == ST_IDLE);
  assign lat_hit  = (cnt_q == LAT);

  always_comb begin
    x_ext  = {1'b0, x_q};
    r_sum  = x_ext - (x_ext >> 3) + ({1'b0, y_q} >> 1);
    result = (r_sum < x_ext) ? x_q : r_sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      b_q       <= '0;
      sat_q     <= 1'b0;
      ra_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      au_a      <= '0;
      au_b      <= '0;
      au_sel    <= SEL_ABS;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            b_q     <= clamp(in_b);
            sat_q   <= (in_a == MOST_NEG) || (in_b == MOST_NEG);
            au_b    <= clamp(in_a);
            au_sel  <= SEL_ABS;
            cnt_q   <= '0;
            state_q <= ST_ABS_A;
          end
        end
        ST_ABS_A: begin
          if (lat_hit) begin
            ra_q    <= au_out;
            au_b    <= b_q;
            au_sel  <= SEL_ABS;
            cnt_q   <= '0;
            state_q <= ST_ABS_B;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ABS_B: begin
          if (lat_hit) begin
            au_a    <= ra_q;
            au_b    <= au_out;
            au_sel  <= SEL_MAX;
            cnt_q   <= '0;
            state_q <= ST_MAX;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_MAX: begin
          if (lat_hit) begin
            x_q     <= au_out;
            au_sel  <= SEL_MIN;
            cnt_q   <= '0;
            state_q <= ST_MIN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_MIN: begin
          if (lat_hit) begin
            y_q     <= au_out;
            au_sel  <= SEL_ABS;
            cnt_q   <= '0;
            state_q <= ST_CALC;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_CALC: begin
          out_data  <= result;
          out_sat   <= sat_q;
          out_valid <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_mag_seq.sv
// Bench for sqrt_mag_seq: models the external AU (1-cycle latency) and checks results
// against an integer magnitude model, plus handshake timing and the AU op sequence.
module tb_sqrt_mag_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_sat;
  logic [W-1:0] au_a;
  logic [W-1:0] au_b;
  logic [1:0]   au_sel;
  logic [W-1:0] au_out = '0;

  int n_cmp = 0;
  int n_fail = 0;

  sqrt_mag_seq #(.W(W), .AU_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .au_a      (au_a),
    .au_b      (au_b),
    .au_sel    (au_sel),
    .au_out    (au_out)
  );

  always #5 clk = ~clk;

  // External arithmetic unit: one register stage between operands and result.
  always @(posedge clk) begin
    case (au_sel)
      2'b00:   au_out <= ($signed(au_b) < 0) ? W'(-$signed(au_b)) : au_b;
      2'b10:   au_out <= ($signed(au_a) < $signed(au_b)) ? au_a : au_b;
      2'b11:   au_out <= ($signed(au_a) > $signed(au_b)) ? au_a : au_b;
      default: au_out <= 'x;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampabs(input int v);
    if (v == -128) return 127;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_mag(input int a, input int b);
    int ca, cb, x, y, r;
    ca = clampabs(a);
    cb = clampabs(b);
    x = (ca > cb) ? ca : cb;
    y = (ca > cb) ? cb : ca;
    r = x - x / 8 + y / 2;
    return (r > x) ? r : x;
  endfunction

  // One full transaction; hold = cycles out_ready stays low once the result is up.
  task automatic run_op(input int a, input int b, input int hold);
    int exp_d, exp_s, ca;
    int sel_exp[8] = '{0, 0, 0, 0, 3, 3, 2, 2};
    exp_d = ref_mag(a, b);
    exp_s = (a == -128 || b == -128) ? 1 : 0;
    ca = (a == -128) ? 127 : a;
    @(negedge clk);
    check("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      // Keep offering junk while busy; it must be ignored.
      in_a = W'($urandom);
      in_b = W'($urandom);
      if (k == 7) in_valid = 1'b0;
      check($sformatf("au_sel[%0d]", k), int'(au_sel), sel_exp[k]);
      check($sformatf("busy_valid[%0d]", k), int'(out_valid), 0);
      check($sformatf("busy_ready[%0d]", k), int'(in_ready), 0);
      if (k == 0) check("au_b_abs_a", int'(au_b), ca & 8'hff);
      if (k == 4) begin
        check("au_a_max", int'(au_a), clampabs(a));
        check("au_b_max", int'(au_b), clampabs(b));
      end
    end
    @(negedge clk);
    check("calc_sel", int'(au_sel), 0);
    check("calc_valid", int'(out_valid), 0);
    @(negedge clk);
    check("valid_at_9", int'(out_valid), 1);
    check("out_data", int'(out_data), exp_d);
    check("out_sat", int'(out_sat), exp_s);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), exp_d);
      check("hold_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_xfer_valid", int'(out_valid), 0);
    check("post_xfer_ready", int'(in_ready), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_sat", int'(out_sat), 0);
    check("rst_au_a", int'(au_a), 0);
    check("rst_au_b", int'(au_b), 0);
    check("rst_au_sel", int'(au_sel), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    // out_ready with nothing pending has no effect
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready_noop", int'(out_valid), 0);

    run_op(3, 4, 0);
    check("ref_3_4", ref_mag(3, 4), 5);
    run_op(-12, 5, 1);
    run_op(10, 1, 0);
    run_op(-128, 0, 2);
    run_op(127, 127, 5);
    run_op(-128, -128, 0);

    // Reset while the MAX op is in flight.
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 8'd50;
    in_b = 8'd60;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_sel_max", int'(au_sel), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_sel", int'(au_sel), 0);
    repeat (12) begin
      @(negedge clk);
      check("mid_rst_no_result", int'(out_valid), 0);
    end
    run_op(0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 255)) - 128;
      rb = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 7) == 0) ra = -128;
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
